sd_block_reader: RTL and testbench

SPI-mode single-block read engine for the SD card path, the read-side counterpart of the SD write engine. On a start request it issues CMD17 for a 32-bit sector address, waits for the R1 response and the start-block token, and streams the 512-byte payload to the user as 256 16-bit words. It drives its own `sd_cs`/`sd_mosi` pair, which the SD controller top muxes onto the card pins after initialisation. It shares `clk_25m` as the card SPI clock.

---
 rtl/sd_pkg.sv | 34 +++
 rtl/sd_crc16.sv | 28 ++
 rtl/sd_block_reader.sv | 249 ++++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared states, constants and helpers for the SD block read path
package sd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_WAIT_R1,
      ST_R1,
      ST_WAIT_TOKEN,
      ST_DATA,
      ST_CRC,
      ST_TAIL,
      ST_ERR
   } sd_state_t;

   localparam logic [7:0]  CMD17_INDEX = 8'h51;
   localparam logic [7:0]  DATA_TOKEN  = 8'hFE;
   localparam logic [7:0]  DUMMY_CRC   = 8'hFF;
   localparam logic [15:0] CRC16_POLY  = 16'h1021;

   localparam int BLOCK_LEN  = 512;
   localparam int WORD_COUNT = 256;
   localparam int TAIL_LEN   = 8;
   localparam int CMD_BITS   = 48;
   localparam int CRC_BITS   = 16;
   localparam int DATA_BITS  = BLOCK_LEN * 8;
   localparam int WORD_BITS  = DATA_BITS / WORD_COUNT;

   // Full CMD17 frame: index, sector address as argument, dummy CRC with end bit.
   function automatic logic [47:0] cmd17_frame(input logic [31:0] addr);
      return {CMD17_INDEX, addr, DUMMY_CRC};
   endfunction

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - bit-serial CRC16-CCITT (poly 0x1021, init 0), MSB first
module sd_crc16
   import sd_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic feedback;

   assign feedback = crc[15] ^ din;

   // One LFSR step per enabled bit; clear has priority so a new block starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= (crc << 1) ^ (feedback ? CRC16_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/sd_block_reader.sv
// rtl/sd_block_reader.sv - SPI-mode CMD17 single-block reader; optional CRC16 check under SD_RD_CRC16_EN
module sd_block_reader
   import sd_pkg::*;
#(
   parameter int R1_TIMEOUT    = 64,
   parameter int TOKEN_TIMEOUT = 1_000_000
) (
   input  logic        clk_25m,
   input  logic        rst_n,
   input  logic        sd_miso,
   output logic        sd_cs,
   output logic        sd_mosi,
   input  logic        init,
   input  logic        rd_start_en,
   input  logic [31:0] rd_sec_addr,
   output logic        rd_busy,
   output logic        rd_val_en,
   output logic [15:0] rd_val_data,
   output logic        rd_err,
   output logic        rd_crc_err
);

   localparam logic [19:0] R1_LIMIT  = 20'(R1_TIMEOUT);
   localparam logic [19:0] TOK_LIMIT = 20'(TOKEN_TIMEOUT);

   sd_state_t   state, state_next;
   logic [47:0] frame_sh, frame_next;
   logic [11:0] cnt, cnt_next;
   logic [19:0] tmo, tmo_next, tmo_inc;
   logic [15:0] shreg, shreg_next, shift_in;
   logic        cs, cs_next;
   logic        mosi, mosi_next;
   logic        busy, busy_next;
   logic        val_en, val_en_next;
   logic [15:0] val_data, val_data_next;
   logic        err, err_next;

   // Timeout counter saturates so a huge parameter can never wrap back to a small count.
   assign tmo_inc  = (tmo == 20'hF_FFFF) ? tmo : tmo + 20'd1;
   assign shift_in = {shreg[14:0], sd_miso};

   // State register.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers and registered card/user outputs; CS and MOSI idle high.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         frame_sh <= '0;
         cnt      <= '0;
         tmo      <= '0;
         shreg    <= '0;
         cs       <= 1'b1;
         mosi     <= 1'b1;
         busy     <= 1'b0;
         val_en   <= 1'b0;
         val_data <= '0;
         err      <= 1'b0;
      end else begin
         frame_sh <= frame_next;
         cnt      <= cnt_next;
         tmo      <= tmo_next;
         shreg    <= shreg_next;
         cs       <= cs_next;
         mosi     <= mosi_next;
         busy     <= busy_next;
         val_en   <= val_en_next;
         val_data <= val_data_next;
         err      <= err_next;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
   always_comb begin
      state_next    = state;
      frame_next    = frame_sh;
      cnt_next      = cnt;
      tmo_next      = tmo;
      shreg_next    = shreg;
      cs_next       = cs;
      mosi_next     = mosi;
      busy_next     = busy;
      val_en_next   = 1'b0;
      val_data_next = val_data;
      err_next      = 1'b0;

      case (state)
         ST_IDLE: begin
            // The frame register doubles as the address latch for the whole transfer.
            if (init && rd_start_en) begin
               frame_next = cmd17_frame(rd_sec_addr);
               mosi_next  = frame_next[47];
               cs_next    = 1'b0;
               busy_next  = 1'b1;
               cnt_next   = '0;
               state_next = ST_CMD;
            end
         end

         ST_CMD: begin
            if (cnt == 12'(CMD_BITS - 1)) begin
               mosi_next  = 1'b1;
               tmo_next   = '0;
               state_next = ST_WAIT_R1;
            end else begin
               frame_next = frame_sh << 1;
               mosi_next  = frame_sh[46];
               cnt_next   = cnt + 12'd1;
            end
         end

         ST_WAIT_R1: begin
            // The R1 start bit is R1 bit 7 and is kept as the first captured bit.
            if (!sd_miso) begin
               shreg_next = shift_in;
               cnt_next   = 12'd1;
               state_next = ST_R1;
            end else if (tmo_inc == R1_LIMIT) begin
               err_next   = 1'b1;
               state_next = ST_ERR;
            end else begin
               tmo_next = tmo_inc;
            end
         end

         ST_R1: begin
            shreg_next = shift_in;
            if (cnt == 12'd7) begin
               if (shift_in[7:0] != 8'h00) begin
                  err_next   = 1'b1;
                  state_next = ST_ERR;
               end else begin
                  tmo_next   = '0;
                  state_next = ST_WAIT_TOKEN;
               end
            end else begin
               cnt_next = cnt + 12'd1;
            end
         end

         ST_WAIT_TOKEN: begin
            // Only the last bit of the start token is zero, so the first zero ends it.
            if (sd_miso == DATA_TOKEN[0]) begin
               cnt_next   = '0;
               state_next = ST_DATA;
            end else if (tmo_inc == TOK_LIMIT) begin
               err_next   = 1'b1;
               state_next = ST_ERR;
            end else begin
               tmo_next = tmo_inc;
            end
         end

         ST_DATA: begin
            shreg_next = shift_in;
            if (cnt[3:0] == 4'(WORD_BITS - 1)) begin
               val_en_next   = 1'b1;
               val_data_next = shift_in;
            end
            if (cnt == 12'(DATA_BITS - 1)) begin
               cnt_next   = '0;
               state_next = ST_CRC;
            end else begin
               cnt_next = cnt + 12'd1;
            end
         end

         ST_CRC: begin
            shreg_next = shift_in;
            if (cnt == 12'(CRC_BITS - 1)) begin
               cs_next    = 1'b1;
               mosi_next  = 1'b1;
               cnt_next   = '0;
               state_next = ST_TAIL;
            end else begin
               cnt_next = cnt + 12'd1;
            end
         end

         ST_TAIL: begin
            // Eight deselected clocks let the card release MISO before the next command.
            if (cnt == 12'(TAIL_LEN - 1)) begin
               busy_next  = 1'b0;
               cnt_next   = '0;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt + 12'd1;
            end
         end

         ST_ERR: begin
            cs_next    = 1'b1;
            mosi_next  = 1'b1;
            cnt_next   = '0;
            state_next = ST_TAIL;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

`ifdef SD_RD_CRC16_EN
   logic [15:0] crc_calc;
   logic        crc_clr;
   logic        crc_en;
   logic        crc_err;

   // Clearing throughout WAIT_TOKEN leaves the generator at zero for the first data bit.
   assign crc_clr = (state == ST_WAIT_TOKEN);
   assign crc_en  = (state == ST_DATA);

   sd_crc16 u_crc16 (
      .clk   (clk_25m),
      .rst_n (rst_n),
      .clr   (crc_clr),
      .en    (crc_en),
      .din   (sd_miso),
      .crc   (crc_calc)
   );

   // Compare on the edge that takes the last CRC bit so the pulse lands in the first TAIL cycle.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         crc_err <= 1'b0;
      end else begin
         crc_err <= (state == ST_CRC) && (cnt == 12'(CRC_BITS - 1)) && (shift_in != crc_calc);
      end
   end

   assign rd_crc_err = crc_err;
`else
   assign rd_crc_err = 1'b0;
`endif

   assign sd_cs       = cs;
   assign sd_mosi     = mosi;
   assign rd_busy     = busy;
   assign rd_val_en   = val_en;
   assign rd_val_data = val_data;
   assign rd_err      = err;

endmodule

// File: tb/tb_sd_block_reader.sv
// tb/tb_sd_block_reader.sv - self-checking bench for sd_block_reader with a behavioural SPI card
`timescale 1ns/1ps
module tb_sd_block_reader;

   localparam int TB_R1_TMO  = 64;
   localparam int TB_TOK_TMO = 200;
`ifdef SD_RD_CRC16_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic        clk_25m = 1'b0;
   logic        rst_n = 1'b0;
   logic        sd_miso = 1'b1;
   logic        init = 1'b0;
   logic        rd_start_en = 1'b0;
   logic [31:0] rd_sec_addr = 32'h0;
   logic        sd_cs;
   logic        sd_mosi;
   logic        rd_busy;
   logic        rd_val_en;
   logic [15:0] rd_val_data;
   logic        rd_err;
   logic        rd_crc_err;

   always #20 clk_25m = ~clk_25m;

   sd_block_reader #(
      .R1_TIMEOUT    (TB_R1_TMO),
      .TOKEN_TIMEOUT (TB_TOK_TMO)
   ) dut (
      .clk_25m     (clk_25m),
      .rst_n       (rst_n),
      .sd_miso     (sd_miso),
      .sd_cs       (sd_cs),
      .sd_mosi     (sd_mosi),
      .init        (init),
      .rd_start_en (rd_start_en),
      .rd_sec_addr (rd_sec_addr),
      .rd_busy     (rd_busy),
      .rd_val_en   (rd_val_en),
      .rd_val_data (rd_val_data),
      .rd_err      (rd_err),
      .rd_crc_err  (rd_crc_err)
   );

   typedef struct {
      logic [31:0] addr;
      int          r1_delay;
      logic [7:0]  r1_val;
      bit          r1_never;
      int          tok_delay;
      bit          tok_never;
      bit          crc_flip;
      bit          poke;
      int          exp_words;
      int          exp_err;
      int          exp_err_off;
   } rec_t;

   rec_t tbl[6];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] exp_q[$];
   int          val_cnt, err_cnt, crc_cnt, first_val_cyc, err_cyc;
   int          c0, tok_cyc, last_cyc;
   logic [47:0] frame_seen;
   logic        busy_at_cs;
   bit          card_seen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return (c << 1) ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   always @(posedge clk_25m) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every word strobe and counts pulses.
   always @(negedge clk_25m) begin
      if (rd_val_en === 1'b1) begin
         val_cnt++;
         if (first_val_cyc == 0) first_val_cyc = cyc;
         if (exp_q.size() == 0) check("unexpected_word", 64'(rd_val_data), 64'hDEAD_0000);
         else check("word", 64'(rd_val_data), 64'(exp_q.pop_front()));
      end
      if (rd_err === 1'b1) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (rd_crc_err === 1'b1) crc_cnt++;
   end

   // Card model: builds the MISO bit stream (pushing expected words), captures the command, plays bits.
   task automatic card(input rec_t r);
      bit          q[$];
      int          tok_idx;
      logic [15:0] crc;
      logic [7:0]  b;
      logic [7:0]  tok;
      tok_idx = -1;
      crc = 16'h0;
      tok = 8'hFE;
      for (int i = 0; i < r.r1_delay; i++) q.push_back(1'b1);
      if (!r.r1_never) begin
         for (int i = 7; i >= 0; i--) q.push_back(r.r1_val[i]);
         if (r.r1_val == 8'h00 && !r.tok_never) begin
            for (int i = 0; i < r.tok_delay; i++) q.push_back(1'b1);
            for (int i = 7; i >= 0; i--) begin
               if (i == 0) tok_idx = q.size();
               q.push_back(tok[i]);
            end
            for (int n = 0; n < 512; n++) begin
               b = n[7:0];
               if (n % 2 == 0) exp_q.push_back({b, b + 8'd1});
               for (int i = 7; i >= 0; i--) begin
                  q.push_back(b[i]);
                  crc = crc_step(crc, b[i]);
               end
            end
            if (r.crc_flip) crc[0] = ~crc[0];
            for (int i = 15; i >= 0; i--) q.push_back(crc[i]);
         end
      end
      card_seen = 1'b0;
      for (int i = 0; i < 12 && !card_seen; i++) begin
         @(negedge clk_25m);
         if (sd_cs === 1'b0) card_seen = 1'b1;
      end
      if (!card_seen) return;
      c0 = cyc;
      busy_at_cs = rd_busy;
      frame_seen = {47'b0, sd_mosi};
      for (int i = 0; i < 47; i++) begin
         @(negedge clk_25m);
         frame_seen = {frame_seen[46:0], sd_mosi};
      end
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk_25m);
         if (sd_cs !== 1'b0) break;
         sd_miso = q[i];
         if (i == tok_idx) tok_cyc = cyc;
         last_cyc = cyc;
      end
      @(negedge clk_25m);
      sd_miso = 1'b1;
   endtask

   task automatic clear_counts();
      val_cnt = 0;
      err_cnt = 0;
      crc_cnt = 0;
      first_val_cyc = 0;
      err_cyc = 0;
      tok_cyc = 0;
      last_cyc = 0;
      card_seen = 1'b0;
      exp_q.delete();
   endtask

   task automatic run_row(input int idx, input rec_t r);
      int fall_cyc;
      int rise_cyc;
      int stray;
      bit done;
      clear_counts();
      @(negedge clk_25m);
      init = 1'b1;
      rd_sec_addr = r.addr;
      rd_start_en = 1'b1;
      fork
         card(r);
      join_none
      @(negedge clk_25m);
      rd_start_en = 1'b0;
      rd_sec_addr = ~r.addr;
      if (r.poke) begin
         repeat (200) @(negedge clk_25m);
         rd_start_en = 1'b1;
         rd_sec_addr = 32'h0BAD_0BAD;
         repeat (3) @(negedge clk_25m);
         rd_start_en = 1'b0;
      end
      done = 1'b0;
      rise_cyc = 0;
      fall_cyc = 0;
      for (int i = 0; i < 6000 && !done; i++) begin
         @(negedge clk_25m);
         if (rise_cyc == 0 && sd_cs === 1'b1) rise_cyc = cyc;
         if (rd_busy === 1'b0) begin
            done = 1'b1;
            fall_cyc = cyc;
         end
      end
      repeat (3) @(negedge clk_25m);
      $display("row %0d addr %08h done", idx, r.addr);
      check("busy_falls", 64'(done), 64'd1);
      check("cs_asserted", 64'(card_seen), 64'd1);
      check("cmd_frame", 64'(frame_seen), {16'h0, 8'h51, r.addr, 8'hFF});
      check("busy_at_t1", 64'(busy_at_cs), 64'd1);
      check("word_count", 64'(val_cnt), 64'(r.exp_words));
      check("err_pulses", 64'(err_cnt), 64'(r.exp_err));
      check("crc_err_pulses", 64'(crc_cnt), CRC_ON ? 64'(r.crc_flip) : 64'd0);
      check("words_left", 64'(exp_q.size()), 64'd0);
      check("tail_len", 64'(fall_cyc - rise_cyc), 64'd8);
      if (r.exp_err_off != 0) begin
         check("err_timing", 64'(err_cyc - c0), 64'(r.exp_err_off));
         check("busy_after_err", 64'(fall_cyc - err_cyc), 64'd9);
      end
      if (r.exp_words != 0) begin
         check("first_word_latency", 64'(first_val_cyc - tok_cyc), 64'd17);
         check("busy_after_crc", 64'(fall_cyc - last_cyc), 64'd9);
      end
      if (r.poke) begin
         stray = 0;
         repeat (20) begin
            @(negedge clk_25m);
            if (sd_cs !== 1'b1 || rd_busy !== 1'b0) stray++;
         end
         check("start_while_busy_ignored", 64'(stray), 64'd0);
      end
   endtask

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int stray;
      tbl[0] = '{32'h0000_1234, 3,  8'h00, 1'b0, 100, 1'b0, 1'b0, 1'b0, 256, 0, 0};
      tbl[1] = '{32'h0000_0010, 3,  8'h04, 1'b0, 0,   1'b0, 1'b0, 1'b0, 0,   1, 59};
      tbl[2] = '{32'hCAFE_F00D, 0,  8'h00, 1'b1, 0,   1'b0, 1'b0, 1'b0, 0,   1, 48 + TB_R1_TMO};
      tbl[3] = '{32'h0000_0777, 3,  8'h00, 1'b0, 0,   1'b1, 1'b0, 1'b0, 0,   1, 59 + TB_TOK_TMO};
      tbl[4] = '{32'hA5A5_5A5A, 0,  8'h00, 1'b0, 5,   1'b0, 1'b1, 1'b1, 256, 0, 0};
      tbl[5] = '{32'h8000_0001, 10, 8'h01, 1'b0, 0,   1'b0, 1'b0, 1'b0, 0,   1, 66};

      repeat (3) @(negedge clk_25m);
      check("reset_outputs", 64'({sd_cs, sd_mosi, rd_busy, rd_val_en, rd_val_data, rd_err, rd_crc_err}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}));
      rst_n = 1'b1;
      repeat (2) @(negedge clk_25m);

      // Start request without init must not touch the card.
      init = 1'b0;
      rd_start_en = 1'b1;
      rd_sec_addr = 32'h0000_0001;
      stray = 0;
      repeat (20) begin
         @(negedge clk_25m);
         if (sd_cs !== 1'b1 || rd_busy !== 1'b0) stray++;
      end
      check("start_gated_by_init", 64'(stray), 64'd0);
      rd_start_en = 1'b0;

      for (int i = 0; i < 6; i++) run_row(i, tbl[i]);

      // Reset at word 100: everything returns to reset values immediately, no more words.
      clear_counts();
      @(negedge clk_25m);
      init = 1'b1;
      rd_sec_addr = 32'h0000_4321;
      rd_start_en = 1'b1;
      fork
         card(tbl[0]);
      join_none
      @(negedge clk_25m);
      rd_start_en = 1'b0;
      n = 0;
      while (val_cnt < 100 && n < 6000) begin
         @(negedge clk_25m);
         #1;
         n++;
      end
      check("reached_word_100", 64'(val_cnt), 64'd100);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 64'({sd_cs, sd_mosi, rd_busy, rd_val_en, rd_val_data, rd_err, rd_crc_err}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}));
      repeat (3) @(negedge clk_25m);
      rst_n = 1'b1;
      repeat (20) @(negedge clk_25m);
      check("no_words_after_reset", 64'(val_cnt), 64'd100);
      check("no_err_after_reset", 64'(err_cnt), 64'd0);
      exp_q.delete();

      run_row(6, tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
